// File: rtl/joydb9_serial_reader_if.sv
// -----------------------------------------------------------------------------
// joydb9_serial_reader_if
//
// Groups the signals of the DB9 joystick serial reader that are not clock or
// reset: the scan enable, the three wires of the shift-register chain, and the
// published joystick words with their valid strobe.
//
// Signals:
//   enable    scanning enable (low aborts the current frame)
//   joy_data  serial data returned by the chain, active-low buttons
//   joy_clk   shift clock to the chain
//   joy_load  parallel-load strobe to the chain, active-low
//   joy1      port 1 buttons, active-high
//   joy2      port 2 buttons, active-high
//   valid     one-cycle strobe marking a joy1/joy2 update
//
// Modports:
//   master  the reader itself (drives the chain and the joystick words)
//   slave   the platform side (drives enable and the chain data line)
// -----------------------------------------------------------------------------
interface joydb9_serial_reader_if;
  logic       enable;
  logic       joy_data;
  logic       joy_clk;
  logic       joy_load;
  logic [7:0] joy1;
  logic [7:0] joy2;
  logic       valid;

  modport master (
    input  enable,
    input  joy_data,
    output joy_clk,
    output joy_load,
    output joy1,
    output joy2,
    output valid
  );

  modport slave (
    output enable,
    output joy_data,
    input  joy_clk,
    input  joy_load,
    input  joy1,
    input  joy2,
    input  valid
  );
endinterface

// File: rtl/joydb9_serial_reader.sv
// -----------------------------------------------------------------------------
// joydb9_serial_reader
//
// Initiator side of the DB9 joystick serial link. A tick divider paces the
// protocol: after an idle gap the chain is parallel-loaded (joy_load low for
// one tick), given one settle tick, then clocked 16 times (each bit is one low
// phase followed by one high phase of joy_clk). The bit is captured from the
// synchronised data line at the end of its low phase, just as joy_clk rises.
// Once all 16 bits are in, a single PUBLISH cycle inverts them onto joy1/joy2
// and pulses valid.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      joydb9_serial_reader_if.master
//              enable, joy_data           inputs
//              joy_clk, joy_load          chain controls, registered
//              joy1, joy2, valid          published words, registered
//
// Parameters:
//   CLK_DIV     system cycles per bit-phase tick (>= 4)
//   IDLE_TICKS  ticks spent idle between frames (>= 1)
// -----------------------------------------------------------------------------
module joydb9_serial_reader #(
  parameter int CLK_DIV    = 50,
  parameter int IDLE_TICKS = 1000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  joydb9_serial_reader_if.master  bus
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDLE_W = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ZERO  = DIV_W'(0);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TICKS - 1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_BIT_LO  = 3'd3,
    ST_BIT_HI  = 3'd4,
    ST_PUBLISH = 3'd5
  } state_e;

  // Data line synchroniser
  logic              sd1_q;
  logic              sd2_q;

  // Tick divider
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic              tick_s;

  // Protocol state
  state_e            state_q;
  state_e            state_d;
  logic [3:0]        bit_idx_q;
  logic [3:0]        bit_idx_d;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [IDLE_W-1:0] idle_cnt_d;
  logic [15:0]       sr_q;
  logic [15:0]       sr_d;

  // Registered outputs
  logic              joy_clk_q;
  logic              joy_clk_d;
  logic              joy_load_q;
  logic              joy_load_d;
  logic [7:0]        joy1_q;
  logic [7:0]        joy1_d;
  logic [7:0]        joy2_q;
  logic [7:0]        joy2_d;
  logic              valid_q;
  logic              valid_d;

  // Two-flop synchroniser for the asynchronous chain data; idles high (released).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sd1_q <= 1'b1;
      sd2_q <= 1'b1;
    end else begin
      sd1_q <= bus.joy_data;
      sd2_q <= sd1_q;
    end
  end

  // The divider only reaches its last count while enabled, so tick implies enable.
  assign tick_s = (div_q == DIV_LAST);

  // Divider next-state: free-runs while enabled, parked at zero when disabled
  // and during the PUBLISH cycle so that cycle adds exactly one to the frame.
  always_comb begin
    div_d = div_q;
    if (!bus.enable || (state_q == ST_PUBLISH)) begin
      div_d = DIV_ZERO;
    end else if (tick_s) begin
      div_d = DIV_ZERO;
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // Next-state and registered-output logic of the frame sequencer.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    idle_cnt_d = idle_cnt_q;
    sr_d       = sr_q;
    joy_clk_d  = joy_clk_q;
    joy_load_d = joy_load_q;
    joy1_d     = joy1_q;
    joy2_d     = joy2_q;
    valid_d    = 1'b0;

    if (!bus.enable) begin
      // Abort: park the chain, forget the partial frame, restart the idle gap.
      state_d    = ST_IDLE;
      joy_clk_d  = 1'b0;
      joy_load_d = 1'b1;
      bit_idx_d  = 4'd0;
      idle_cnt_d = IDLE_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick_s) begin
            if (idle_cnt_q == IDLE_LAST) begin
              idle_cnt_d = IDLE_ZERO;
              joy_load_d = 1'b0;
              state_d    = ST_LOAD;
            end else begin
              idle_cnt_d = idle_cnt_q + IDLE_ONE;
            end
          end else begin
            idle_cnt_d = idle_cnt_q;
          end
        end

        ST_LOAD: begin
          if (tick_s) begin
            joy_load_d = 1'b1;
            state_d    = ST_SETTLE;
          end else begin
            joy_load_d = 1'b0;
          end
        end

        // One extra tick lets the chain's first bit settle after load release.
        ST_SETTLE: begin
          if (tick_s) begin
            state_d = ST_BIT_LO;
          end else begin
            state_d = ST_SETTLE;
          end
        end

        // Capture at the end of the low phase, together with the rising joy_clk.
        ST_BIT_LO: begin
          if (tick_s) begin
            sr_d[bit_idx_q] = sd2_q;
            joy_clk_d       = 1'b1;
            state_d         = ST_BIT_HI;
          end else begin
            joy_clk_d = 1'b0;
          end
        end

        ST_BIT_HI: begin
          if (tick_s) begin
            joy_clk_d = 1'b0;
            if (bit_idx_q == 4'd15) begin
              state_d = ST_PUBLISH;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
              state_d   = ST_BIT_LO;
            end
          end else begin
            joy_clk_d = 1'b1;
          end
        end

        // Wire is active-low, published words are active-high.
        ST_PUBLISH: begin
          joy1_d     = ~sr_q[7:0];
          joy2_d     = ~sr_q[15:8];
          valid_d    = 1'b1;
          bit_idx_d  = 4'd0;
          idle_cnt_d = IDLE_ZERO;
          state_d    = ST_IDLE;
        end

        default: begin
          state_d    = ST_IDLE;
          joy_clk_d  = 1'b0;
          joy_load_d = 1'b1;
          bit_idx_d  = 4'd0;
          idle_cnt_d = IDLE_ZERO;
        end
      endcase
    end
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= DIV_ZERO;
      state_q    <= ST_IDLE;
      bit_idx_q  <= 4'd0;
      idle_cnt_q <= IDLE_ZERO;
      sr_q       <= 16'hFFFF;
      joy_clk_q  <= 1'b0;
      joy_load_q <= 1'b1;
      joy1_q     <= 8'h00;
      joy2_q     <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      idle_cnt_q <= idle_cnt_d;
      sr_q       <= sr_d;
      joy_clk_q  <= joy_clk_d;
      joy_load_q <= joy_load_d;
      joy1_q     <= joy1_d;
      joy2_q     <= joy2_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.joy_clk  = joy_clk_q;
  assign bus.joy_load = joy_load_q;
  assign bus.joy1     = joy1_q;
  assign bus.joy2     = joy2_q;
  assign bus.valid    = valid_q;

endmodule
